muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: consumes the two read ports (rs1/rs2 values) and produces a 32-bit result plus destination index for the write-back port (WD/A3/We).
- Multi-cycle with a start/done handshake; the pipeline/controller stalls on busy.

---
 rtl/riscv_m_pkg.sv | 33 +++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   - XLEN            : datapath width
//   - F3_*            : funct3 opcodes of the M extension
//   - md_state_e      : controller states
//   - neg_if/neg_if_dw: conditional two's-complement negate, single and double width
package riscv_m_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } md_state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_dw(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a start/done handshake.
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   start             : request, sampled only while busy is low
//   funct3            : M-extension operation select
//   rs1_val, rs2_val  : operands from the register file read ports
//   rd_in             : destination register of the request
//   busy              : high while iterating
//   done              : one-cycle completion pulse (write enable)
//   result, rd_out    : completed result and destination, held until the next completion
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import riscv_m_pkg::*;

  localparam int unsigned CntW = $clog2(ITER);

  md_state_e         state;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;   // operand signs after signedness is applied
  logic [XLEN-1:0]   opb_q;        // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_q;        // {product hi / remainder, multiplier / quotient}
  logic [CntW-1:0]   cnt_q;

  // Request decode
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            spec_hit;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed & rs1_val[XLEN-1];
    b_neg    = b_signed & rs2_val[XLEN-1];
    a_mag    = neg_if(rs1_val, a_neg);
    b_mag    = neg_if(rs2_val, b_neg);

    // funct3[2]: divide family, funct3[1]: remainder, funct3[0]: unsigned
    spec_hit = 1'b0;
    spec_res = '0;
    if (funct3[2]) begin
      if (rs2_val == '0) begin
        spec_hit = 1'b1;
        spec_res = funct3[1] ? rs1_val : '1;
      end else if (!funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1)) begin
        spec_hit = 1'b1;
        spec_res = funct3[1] ? '0 : rs1_val;
      end
    end
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   quo, rem, fin;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    if (op_q[2]) begin
      // No borrow out means the trial remainder covered the divisor
      if (!div_diff[XLEN]) acc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end

    prod = neg_if_dw(acc_nxt, sa_q ^ sb_q);
    quo  = neg_if(acc_nxt[XLEN-1:0], sa_q ^ sb_q);
    rem  = neg_if(acc_nxt[2*XLEN-1:XLEN], sa_q);
    fin  = '0;
    unique case (op_q)
      F3_MUL:                       fin = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fin = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fin = quo;
      F3_REM, F3_REMU:              fin = rem;
      default:                      fin = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      opb_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            op_q  <= funct3;
            rd_q  <= rd_in;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            cnt_q <= '0;
            if (spec_hit) begin
              result <= spec_res;
              rd_out <= rd_in;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= StDone;
            end else begin
              opb_q <= funct3[2] ? b_mag : a_mag;
              acc_q <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
              busy  <= 1'b1;
              state <= StCalc;
            end
          end else begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        StCalc: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(ITER - 1)) begin
            result <= fin;
            rd_out <= rd_q;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {result, rd, latency}.
module tb_muldiv_unit;
  import riscv_m_pkg::*;

  localparam int MaxLat = 60;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_in, rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_in(rd_in), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  // Reference model of the M-extension semantics
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, b);
    logic [63:0]        p;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f)
      F3_MUL:    begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0];  end
      F3_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      F3_MULHSU: begin p = {{32{a[31]}}, a} * {32'h0, b};       return p[63:32]; end
      F3_MULHU:  begin p = {32'h0, a} * {32'h0, b};             return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, b);
    if (f[2] && (b == 0)) return 1;
    if ((f == F3_DIV || f == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one request and observes its completion; poke_at>0 fires a spurious start
  // with junk operands while the op is in flight.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, b, input logic [4:0] rd,
                        input int poke_at,
                        output logic [31:0] r, output logic [4:0] d, output int lat);
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < MaxLat) begin
      start = (lat == poke_at);
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    r = result;
    d = rd_out;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd_out); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops[4];
    logic [31:0] r;
    logic [4:0]  d;
    int          lat;
    exp_t        e;
    ops = '{F3_MUL, F3_MULHU, F3_MULH, F3_MULHSU};
    sb_q.push_back('{32'hFFFF_FFF9, 5'd9, 33});
    sb_q.push_back('{32'h0000_0006, 5'd9, 33});
    sb_q.push_back('{32'hFFFF_FFFF, 5'd9, 33});
    sb_q.push_back('{32'hFFFF_FFFF, 5'd9, 33});
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'd7, 5'd9, 0, r, d, lat);
      e = sb_q.pop_front();
      n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL mul_res[%0d]: got %h want %h", i, r, e.res); end
      n_checks++; if (d !== e.rd) begin n_fail++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, d, e.rd); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops[8];
    logic [31:0] as[8], bs[8];
    logic [31:0] r;
    logic [4:0]  d;
    int          lat;
    exp_t        e;
    ops = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIVU, F3_REM, F3_DIV, F3_REM};
    as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    sb_q.push_back('{32'hFFFF_FFFD, 5'd1, 33});
    sb_q.push_back('{32'hFFFF_FFFF, 5'd2, 33});
    sb_q.push_back('{32'h7FFF_FFFC, 5'd3, 33});
    sb_q.push_back('{32'h0000_0001, 5'd4, 33});
    sb_q.push_back('{32'hFFFF_FFFF, 5'd5, 1});
    sb_q.push_back('{32'd123,       5'd6, 1});
    sb_q.push_back('{32'h8000_0000, 5'd7, 1});
    sb_q.push_back('{32'h0000_0000, 5'd8, 1});
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 1), 0, r, d, lat);
      e = sb_q.pop_front();
      n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL div_res[%0d]: got %h want %h", i, r, e.res); end
      n_checks++; if (d !== e.rd) begin n_fail++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, d, e.rd); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] r;
    logic [4:0]  d;
    int          lat;
    exp_t        e;
    sb_q.push_back('{32'd1000, 5'd12, 33});
    run_op(F3_DIVU, 32'd7000, 32'd7, 5'd12, 5, r, d, lat);
    e = sb_q.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL ignore_res: got %h want %h", r, e.res); end
    n_checks++; if (d !== e.rd) begin n_fail++; $display("FAIL ignore_rd: got %0d want %0d", d, e.rd); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL ignore_lat: got %0d want %0d", lat, e.lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [4:0]  d;
    int          lat;
    exp_t        e;
    sb_q.push_back('{32'd14, 5'd3, 33});
    sb_q.push_back('{32'd2,  5'd4, 33});
    run_op(F3_DIVU, 32'd100, 32'd7, 5'd3, 0, r, d, lat);
    e = sb_q.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL b2b_res0: got %h want %h", r, e.res); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b_lat0: got %0d want %0d", lat, e.lat); end
    // Second request lands on the DONE cycle of the first
    run_op(F3_REMU, 32'd100, 32'd7, 5'd4, 0, r, d, lat);
    e = sb_q.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL b2b_res1: got %h want %h", r, e.res); end
    n_checks++; if (d !== e.rd) begin n_fail++; $display("FAIL b2b_rd1: got %0d want %0d", d, e.rd); end
    n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b_lat1: got %0d want %0d", lat, e.lat); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: got done=%b want 0", done); end
    n_checks++; if (result !== 32'd2) begin n_fail++; $display("FAIL b2b_hold: got %h want 2", result); end
  endtask

  task automatic test_reset_mid_calc();
    int pulses = 0;
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'd3; rs2_val = 32'd5; rd_in = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h want 0", result); end
    n_checks++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL abort_rd: got %h want 0", rd_out); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_sweep();
    logic [2:0]  ops[3];
    logic [2:0]  tmp, f;
    logic [31:0] a, b, r;
    logic [4:0]  d;
    int          lat, j;
    exp_t        e;
    ops = '{F3_MUL, F3_MULH, F3_MULHU};
    for (int i = 2; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = ops[i]; ops[i] = ops[j]; ops[j] = tmp;
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{(ops[i] == F3_MUL) ? 32'h0 : 32'h4000_0000, 5'(20 + i), 33});
      run_op(ops[i], 32'h8000_0000, 32'h8000_0000, 5'(20 + i), 0, r, d, lat);
      e = sb_q.pop_front();
      n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL sweep_res[f=%0d]: got %h want %h", ops[i], r, e.res); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL sweep_lat[f=%0d]: got %0d want %0d", ops[i], lat, e.lat); end
    end
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(3, 0) == 0) ? 32'h0 : $urandom;
      if (i == 5) begin f = F3_REM; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      d = 5'($urandom);
      sb_q.push_back('{model(f, a, b), d, model_lat(f, a, b)});
      run_op(f, a, b, d, 0, r, d, lat);
      e = sb_q.pop_front();
      n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL rand_res[%0d f=%0d a=%h b=%h]: got %h want %h", i, f, a, b, r, e.res); end
      n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_calc();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
